// File: rtl/apb_cmd_sequencer.sv
// Command FIFO and one-at-a-time issue FSM feeding the APB master bridge request port.
// Optional BUSY watchdog is enabled by defining APB_SEQ_TIMEOUT_EN.
module apb_cmd_sequencer #(
  parameter int unsigned AW      = 9,
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [DW-1:0]          cmd_wdata,
  output logic                   transfer,
  output logic                   read_write,
  output logic [AW-1:0]          apb_write_paddr,
  output logic [DW-1:0]          apb_write_data,
  output logic [AW-1:0]          apb_read_paddr,
  input  logic [DW-1:0]          apb_read_data_out,
  input  logic                   xfer_done,
  output logic                   rsp_valid,
  output logic                   rsp_write,
  output logic [DW-1:0]          rsp_rdata,
  output logic                   rsp_timeout,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t state, state_nxt;

  logic          mem_write [DEPTH];
  logic [AW-1:0] mem_addr  [DEPTH];
  logic [DW-1:0] mem_wdata [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, abort;

  logic          transfer_nxt, read_write_nxt;
  logic [AW-1:0] wpaddr_nxt, rpaddr_nxt;
  logic [DW-1:0] wdata_nxt, rsp_rdata_nxt;
  logic          rsp_valid_nxt, rsp_write_nxt;

  // Readiness looks at the stored count only, so a same-cycle pop never frees a full FIFO.
  assign cmd_ready  = (count != CW'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign fifo_count = count;

  always_ff @(posedge pclk) begin
    if (push) begin
      mem_write[wr_ptr] <= cmd_write;
      mem_addr[wr_ptr]  <= cmd_addr;
      mem_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef APB_SEQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] busy_cnt;

  // A completion arriving in the final watchdog cycle takes priority over the abort.
  assign abort = (state == BUSY) && !xfer_done && (busy_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      busy_cnt    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (pop)
        busy_cnt <= '0;
      else if (state == BUSY)
        busy_cnt <= busy_cnt + TW'(1);
      if (state == BUSY) begin
        if (xfer_done)
          rsp_timeout <= 1'b0;
        else if (abort)
          rsp_timeout <= 1'b1;
      end
    end
  end
`else
  localparam int unsigned timeout_unused = TIMEOUT;

  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    transfer_nxt   = transfer;
    read_write_nxt = read_write;
    wpaddr_nxt     = apb_write_paddr;
    wdata_nxt      = apb_write_data;
    rpaddr_nxt     = apb_read_paddr;
    rsp_valid_nxt  = 1'b0;
    rsp_write_nxt  = rsp_write;
    rsp_rdata_nxt  = rsp_rdata;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nxt      = BUSY;
          transfer_nxt   = 1'b1;
          read_write_nxt = mem_write[rd_ptr];
          if (mem_write[rd_ptr]) begin
            wpaddr_nxt = mem_addr[rd_ptr];
            wdata_nxt  = mem_wdata[rd_ptr];
          end else begin
            rpaddr_nxt = mem_addr[rd_ptr];
          end
        end
      end
      BUSY: begin
        if (xfer_done) begin
          state_nxt     = GAP;
          transfer_nxt  = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = read_write;
          rsp_rdata_nxt = read_write ? '0 : apb_read_data_out;
        end else if (abort) begin
          state_nxt     = GAP;
          transfer_nxt  = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = read_write;
          rsp_rdata_nxt = '0;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      transfer        <= 1'b0;
      read_write      <= 1'b0;
      apb_write_paddr <= '0;
      apb_write_data  <= '0;
      apb_read_paddr  <= '0;
      rsp_valid       <= 1'b0;
      rsp_write       <= 1'b0;
      rsp_rdata       <= '0;
    end else begin
      transfer        <= transfer_nxt;
      read_write      <= read_write_nxt;
      apb_write_paddr <= wpaddr_nxt;
      apb_write_data  <= wdata_nxt;
      apb_read_paddr  <= rpaddr_nxt;
      rsp_valid       <= rsp_valid_nxt;
      rsp_write       <= rsp_write_nxt;
      rsp_rdata       <= rsp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Self-checking bench for apb_cmd_sequencer: directed scenarios plus randomized traffic
// checked by a queue-based command/response model. Covers the APB_SEQ_TIMEOUT_EN build too.
module tb_apb_cmd_sequencer;

  localparam int unsigned AW      = 9;
  localparam int unsigned DW      = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          transfer, read_write;
  logic [AW-1:0] apb_write_paddr, apb_read_paddr;
  logic [DW-1:0] apb_write_data;
  logic [DW-1:0] apb_read_data_out = '0;
  logic          xfer_done = 1'b0;
  logic          rsp_valid, rsp_write, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;

  apb_cmd_sequencer #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .transfer(transfer), .read_write(read_write),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
    .xfer_done(xfer_done),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .fifo_count(fifo_count)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  // Reference model: accepted-but-unissued commands in a queue, one in-flight command,
  // and the rule that a new issue needs the requester idle and not in its one-cycle gap.
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t          q[$];
  cmd_t          cur;
  cmd_t          m_pc;
  bit            gap_pending = 1'b0;
  int            busy_len = 0;
  logic          m_pv, m_pr, m_pxd, m_ptr, exp_rise, exp_rsp, exp_to, exp_tr;
  logic [DW-1:0] m_prd, exp_rd;

  always @(posedge pclk) begin
    m_pv    = cmd_valid;
    m_pr    = cmd_ready;
    m_pxd   = xfer_done;
    m_ptr   = transfer;
    m_prd   = apb_read_data_out;
    m_pc.wr   = cmd_write;
    m_pc.addr = cmd_addr;
    m_pc.data = cmd_wdata;
    #1;
    if (preset) begin
      q.delete();
      gap_pending = 1'b0;
      busy_len    = 0;
    end else begin
      exp_rise = !m_ptr && !gap_pending && (q.size() > 0);
      exp_rsp  = 1'b0;
      exp_to   = 1'b0;
      if (m_ptr) begin
        busy_len++;
        if (m_pxd) exp_rsp = 1'b1;
`ifdef APB_SEQ_TIMEOUT_EN
        else if (busy_len == TIMEOUT) begin
          exp_rsp = 1'b1;
          exp_to  = 1'b1;
        end
`endif
      end
      if (m_pv && m_pr) begin
        q.push_back(m_pc);
        acc_cnt++;
      end
      if (rsp_valid === 1'b1) rsp_cnt++;

      checks++;
      if (rsp_valid !== exp_rsp) begin
        errors++;
        $display("FAIL mon_rsp_valid: got %b expected %b at %0t", rsp_valid, exp_rsp, $time);
      end
      if (exp_rsp) begin
        exp_rd = (cur.wr || exp_to) ? '0 : m_prd;
        checks++;
        if (rsp_write !== cur.wr || rsp_rdata !== exp_rd || rsp_timeout !== exp_to) begin
          errors++;
          $display("FAIL mon_rsp_fields: got w=%b d=%h to=%b expected w=%b d=%h to=%b at %0t",
                   rsp_write, rsp_rdata, rsp_timeout, cur.wr, exp_rd, exp_to, $time);
        end
      end

      exp_tr = exp_rise ? 1'b1 : (m_ptr && !exp_rsp);
      checks++;
      if (transfer !== exp_tr) begin
        errors++;
        $display("FAIL mon_transfer: got %b expected %b at %0t", transfer, exp_tr, $time);
      end
      if (exp_rise) begin
        cur = q.pop_front();
        busy_len = 0;
      end
      if (exp_tr) begin
        checks++;
        if (read_write !== cur.wr ||
            (cur.wr && (apb_write_paddr !== cur.addr || apb_write_data !== cur.data)) ||
            (!cur.wr && apb_read_paddr !== cur.addr)) begin
          errors++;
          $display("FAIL mon_request: got rw=%b wa=%h wd=%h ra=%h expected rw=%b a=%h d=%h at %0t",
                   read_write, apb_write_paddr, apb_write_data, apb_read_paddr,
                   cur.wr, cur.addr, cur.data, $time);
        end
      end

      checks++;
      if (fifo_count !== CW'(q.size()) || cmd_ready !== (q.size() != DEPTH)) begin
        errors++;
        $display("FAIL mon_count: got count=%0d ready=%b expected count=%0d ready=%b at %0t",
                 fifo_count, cmd_ready, q.size(), (q.size() != DEPTH), $time);
      end
      gap_pending = exp_rsp;
    end
  end

  task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic drain();
    int quiet = 0;
    int g = 0;
    cmd_valid = 1'b0;
    while (quiet < 3 && g < 400) begin
      @(negedge pclk);
      g++;
      apb_read_data_out = DW'($urandom);
      xfer_done = (transfer === 1'b1);
      if (transfer === 1'b0 && fifo_count === '0) quiet++;
      else quiet = 0;
    end
    xfer_done = 1'b0;
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL drain_bound: got busy after %0d cycles expected idle", g);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (transfer !== 1'b0 || cmd_ready !== 1'b1 || fifo_count !== '0 || rsp_valid !== 1'b0 ||
        read_write !== 1'b0 || apb_write_paddr !== '0 || apb_write_data !== '0 ||
        apb_read_paddr !== '0 || rsp_rdata !== '0 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got tr=%b rdy=%b cnt=%0d rv=%b rw=%b expected 0 1 0 0 0",
               transfer, cmd_ready, fifo_count, rsp_valid, read_write);
    end
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
  endtask

  task automatic test_write();
    push_cmd(1'b1, 9'h105, 8'hA5);
    @(negedge pclk);
    cmd_valid = 1'b0;
    checks++;
    if (transfer !== 1'b0 || fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL write_queued: got tr=%b cnt=%0d expected tr=0 cnt=1", transfer, fifo_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      checks++;
      if (transfer !== 1'b1 || read_write !== 1'b1 || apb_write_paddr !== 9'h105 ||
          apb_write_data !== 8'hA5 || fifo_count !== '0) begin
        errors++;
        $display("FAIL write_request_%0d: got tr=%b rw=%b a=%h d=%h cnt=%0d expected 1 1 105 a5 0",
                 i, transfer, read_write, apb_write_paddr, apb_write_data, fifo_count);
      end
      if (i == 2) xfer_done = 1'b1;
    end
    @(negedge pclk);
    xfer_done = 1'b0;
    checks++;
    if (transfer !== 1'b0 || rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL write_response: got tr=%b rv=%b rw=%b rd=%h expected 0 1 1 00",
               transfer, rsp_valid, rsp_write, rsp_rdata);
    end
    @(negedge pclk);
    checks++;
    if (transfer !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_gap: got tr=%b rv=%b expected 0 0", transfer, rsp_valid);
    end
  endtask

  task automatic test_read();
    push_cmd(1'b0, 9'h012, 8'hEE);
    @(negedge pclk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk);
      checks++;
      if (transfer !== 1'b1 || read_write !== 1'b0 || apb_read_paddr !== 9'h012 ||
          apb_write_paddr !== 9'h105 || apb_write_data !== 8'hA5) begin
        errors++;
        $display("FAIL read_request_%0d: got tr=%b rw=%b ra=%h wa=%h wd=%h expected 1 0 012 105 a5",
                 i, transfer, read_write, apb_read_paddr, apb_write_paddr, apb_write_data);
      end
      if (i == 1) begin
        xfer_done = 1'b1;
        apb_read_data_out = 8'h3C;
      end
    end
    @(negedge pclk);
    xfer_done = 1'b0;
    apb_read_data_out = 8'h00;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 8'h3C || transfer !== 1'b0) begin
      errors++;
      $display("FAIL read_response: got rv=%b rw=%b rd=%h tr=%b expected 1 0 3c 0",
               rsp_valid, rsp_write, rsp_rdata, transfer);
    end
    @(negedge pclk);
  endtask

  task automatic test_full();
    int acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (cmd_ready === 1'b1) acc++;
      cmd_valid = 1'b1;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
    checks++;
    if (acc != 5 || fifo_count !== CW'(DEPTH) || cmd_ready !== 1'b0 || transfer !== 1'b1) begin
      errors++;
      $display("FAIL full: got acc=%0d cnt=%0d rdy=%b tr=%b expected 5 4 0 1",
               acc, fifo_count, cmd_ready, transfer);
    end
    drain();
  endtask

  task automatic test_order();
    logic [DW-1:0] rd_tab [4];
    logic          exp_w  [4];
    logic [DW-1:0] exp_d  [4];
    int hi = 0, nrsp = 0, issued = 0;
    rd_tab[0] = 8'h00; rd_tab[1] = 8'h5A; rd_tab[2] = 8'h00; rd_tab[3] = 8'hC3;
    exp_w[0] = 1'b1; exp_w[1] = 1'b0; exp_w[2] = 1'b1; exp_w[3] = 1'b0;
    exp_d[0] = 8'h00; exp_d[1] = 8'h5A; exp_d[2] = 8'h00; exp_d[3] = 8'hC3;
    for (int cyc = 0; cyc < 200 && nrsp < 4; cyc++) begin
      @(negedge pclk);
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_write !== exp_w[nrsp] || rsp_rdata !== exp_d[nrsp]) begin
          errors++;
          $display("FAIL order_rsp_%0d: got w=%b d=%h expected w=%b d=%h",
                   nrsp, rsp_write, rsp_rdata, exp_w[nrsp], exp_d[nrsp]);
        end
        nrsp++;
      end
      xfer_done = 1'b0;
      if (transfer === 1'b1) begin
        hi++;
        if (hi == 2) begin
          xfer_done = 1'b1;
          apb_read_data_out = rd_tab[issued % 4];
          issued++;
          hi = 0;
        end
      end else begin
        hi = 0;
      end
      cmd_valid = (cyc < 4);
      case (cyc)
        0: begin cmd_write = 1'b1; cmd_addr = 9'h001; cmd_wdata = 8'h11; end
        1: begin cmd_write = 1'b0; cmd_addr = 9'h002; cmd_wdata = 8'h99; end
        2: begin cmd_write = 1'b1; cmd_addr = 9'h003; cmd_wdata = 8'h33; end
        3: begin cmd_write = 1'b0; cmd_addr = 9'h004; cmd_wdata = 8'h99; end
        default: ;
      endcase
    end
    xfer_done = 1'b0;
    checks++;
    if (nrsp != 4) begin
      errors++;
      $display("FAIL order_count: got %0d responses expected 4", nrsp);
    end
    drain();
  endtask

`ifdef APB_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0, lo = 0;
    apb_read_data_out = 8'hFF;
    push_cmd(1'b0, 9'h0C0, 8'h00);
    push_cmd(1'b1, 9'h0D0, 8'h5D);
    @(negedge pclk);
    cmd_valid = 1'b0;
    while (transfer === 1'b1 && hi < 40) begin
      hi++;
      @(negedge pclk);
    end
    checks++;
    if (hi != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_len: got %0d high cycles expected %0d", hi, TIMEOUT);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 8'h00 || rsp_write !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rsp: got rv=%b to=%b rd=%h rw=%b expected 1 1 00 0",
               rsp_valid, rsp_timeout, rsp_rdata, rsp_write);
    end
    while (transfer !== 1'b1 && lo < 10) begin
      lo++;
      @(negedge pclk);
    end
    checks++;
    if (lo != 2 || read_write !== 1'b1 || apb_write_paddr !== 9'h0D0) begin
      errors++;
      $display("FAIL timeout_next: got lo=%0d rw=%b wa=%h expected 2 1 0d0",
               lo, read_write, apb_write_paddr);
    end
    drain();
  endtask
`endif

  task automatic test_reset_mid_busy();
    push_cmd(1'b0, 9'h0AA, 8'h00);
    push_cmd(1'b1, 9'h1F0, 8'h77);
    @(negedge pclk);
    cmd_valid = 1'b0;
    checks++;
    if (transfer !== 1'b1 || fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL rst_pre: got tr=%b cnt=%0d expected 1 1", transfer, fifo_count);
    end
    #2 preset = 1'b1;
    #1;
    checks++;
    if (transfer !== 1'b0 || fifo_count !== '0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        read_write !== 1'b0 || apb_read_paddr !== '0) begin
      errors++;
      $display("FAIL rst_async: got tr=%b cnt=%0d rdy=%b rv=%b rw=%b ra=%h expected 0 0 1 0 0 000",
               transfer, fifo_count, cmd_ready, rsp_valid, read_write, apb_read_paddr);
    end
    @(negedge pclk);
    preset = 1'b0;
    xfer_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      xfer_done = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || transfer !== 1'b0 || fifo_count !== '0) begin
        errors++;
        $display("FAIL rst_after_%0d: got rv=%b tr=%b cnt=%0d expected 0 0 0",
                 i, rsp_valid, transfer, fifo_count);
      end
    end
  endtask

  task automatic test_random();
    int lat = 1, hi = 0;
    int acc0 = acc_cnt;
    int rsp0 = rsp_cnt;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge pclk);
      xfer_done = 1'b0;
      if (transfer === 1'b1) begin
        hi++;
        if (hi >= lat) begin
          xfer_done = 1'b1;
          lat = $urandom_range(1, 4);
          hi  = 0;
        end
      end else begin
        hi = 0;
        if ($urandom_range(0, 7) == 0) xfer_done = 1'b1;
      end
      apb_read_data_out = DW'($urandom);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
    end
    drain();
    checks++;
    if ((rsp_cnt - rsp0) != (acc_cnt - acc0) || (acc_cnt - acc0) == 0) begin
      errors++;
      $display("FAIL random_rsp_count: got %0d responses expected %0d (nonzero)",
               rsp_cnt - rsp0, acc_cnt - acc0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_full();
    test_order();
`ifdef APB_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
